fsm_bit_serializer: RTL and testbench

- Upstream feeder for the single-bit-input Moore sequence FSM.
- Accepts parallel words over a valid/ready handshake and emits them as a serial bit stream, one bit per clock.
- Inserts a programmable idle gap between words so the downstream FSM sees a defined low level between frames.
- `bit_out` connects directly to the downstream FSM's `in` port. `bit_valid` and `frame_done` are for monitoring and sequencing.

---
 rtl/fsm_bit_serializer.sv | 204 ++++++++++++++++++++
 tb/tb_fsm_bit_serializer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_bit_serializer.sv
// Parallel-to-serial feeder for the single-bit Moore sequence FSM: valid/ready word intake,
// one bit per clock, programmable idle gap. Optional even-parity bit with FSM_SER_PARITY_EN.
module fsm_bit_serializer #(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 2,
    parameter int MSB_FIRST  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             frame_done,
    output logic             busy
);

`ifdef FSM_SER_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int BCW = $clog2(FRAME_LEN + 1);
    localparam int GCW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [BCW-1:0] BIT_LAST  = BCW'(FRAME_LEN - 1);
    localparam logic [BCW-1:0] DATA_LAST = BCW'(WIDTH - 1);
    localparam logic [BCW-1:0] BIT_ONE   = BCW'(1);
    localparam logic [GCW-1:0] GAP_LAST  = GCW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam logic [GCW-1:0] GAP_ONE   = GCW'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [GCW-1:0]   gap_cnt_q, gap_cnt_d;
    logic             bit_out_q, bit_out_d;
    logic             bit_valid_q, bit_valid_d;
    logic             frame_done_q, frame_done_d;
    logic             busy_q, busy_d;
    logic             accept_s;
`ifdef FSM_SER_PARITY_EN
    logic             parity_q, parity_d;

    function automatic logic even_parity(input logic [WIDTH-1:0] w);
        return ^w;
    endfunction
`endif

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        if (MSB_FIRST != 0) begin
            return w[WIDTH-1];
        end else begin
            return w[0];
        end
    endfunction

    assign accept_s   = data_valid && (state_q == S_IDLE);
    assign data_ready = (state_q == S_IDLE) && !reset;
    assign bit_out    = bit_out_q;
    assign bit_valid  = bit_valid_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            bit_out_q    <= 1'b0;
            bit_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef FSM_SER_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            bit_out_q    <= bit_out_d;
            bit_valid_q  <= bit_valid_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
`ifdef FSM_SER_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    // Next-state decode; the unused encoding falls back to IDLE.
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (bit_cnt_q == BIT_LAST) begin
                    state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_GAP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output/datapath next values: outputs are computed one cycle ahead so they come straight from flops.
    always_comb begin
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = '0;
        bit_out_d    = 1'b0;
        bit_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        busy_d       = 1'b0;
`ifdef FSM_SER_PARITY_EN
        parity_d     = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    shreg_d     = data_in;
                    bit_cnt_d   = '0;
                    bit_out_d   = first_bit(data_in);
                    bit_valid_d = 1'b1;
                    busy_d      = 1'b1;
`ifdef FSM_SER_PARITY_EN
                    parity_d    = even_parity(data_in);
`endif
                end else begin
                    bit_cnt_d   = '0;
                end
            end
            S_SHIFT: begin
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d = '0;
                    busy_d    = (GAP_CYCLES > 0);
                end else begin
                    bit_cnt_d    = bit_cnt_q + BIT_ONE;
                    bit_valid_d  = 1'b1;
                    busy_d       = 1'b1;
                    frame_done_d = ((bit_cnt_q + BIT_ONE) == BIT_LAST);
                    // The register head always holds the bit on the wire, so the next one sits one place in.
                    if (MSB_FIRST != 0) begin
                        shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
                        bit_out_d = shreg_q[WIDTH-2];
                    end else begin
                        shreg_d   = {1'b0, shreg_q[WIDTH-1:1]};
                        bit_out_d = shreg_q[1];
                    end
`ifdef FSM_SER_PARITY_EN
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_out_d = parity_q;
                    end else begin
                        bit_out_d = bit_out_d;
                    end
`else
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_out_d = 1'b0;
                    end else begin
                        bit_out_d = bit_out_d;
                    end
`endif
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    busy_d    = 1'b0;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_ONE;
                    busy_d    = 1'b1;
                end
            end
            default: begin
                shreg_d   = '0;
                bit_cnt_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_fsm_bit_serializer.sv
// Bench for fsm_bit_serializer: default, LSB-first and zero-gap instances against a frame-queue model.
module tb_fsm_bit_serializer;
    localparam int W = 8;
`ifdef FSM_SER_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       data_valid;
    logic       rdy [3];
    logic       bo  [3];
    logic       bv  [3];
    logic       fd  [3];
    logic       bz  [3];

    always #5 clk = ~clk;

    fsm_bit_serializer u0 (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(rdy[0]), .bit_out(bo[0]), .bit_valid(bv[0]), .frame_done(fd[0]), .busy(bz[0]));
    fsm_bit_serializer #(.MSB_FIRST(0)) u1 (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(rdy[1]), .bit_out(bo[1]), .bit_valid(bv[1]), .frame_done(fd[1]), .busy(bz[1]));
    fsm_bit_serializer #(.GAP_CYCLES(0)) u2 (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(rdy[2]), .bit_out(bo[2]), .bit_valid(bv[2]), .frame_done(fd[2]), .busy(bz[2]));

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Model: per instance, queue of {bit, valid, done, busy} for the current and future cycles.
    logic [3:0] mq0[$];
    logic [3:0] mq1[$];
    logic [3:0] mq2[$];
    int acc0[$];
    int acc2[$];

    typedef struct {
        logic [7:0] w;
        logic [7:0] msb;
        logic [7:0] lsb;
        logic       par;
    } vec_t;
    vec_t tbl[6];

    function automatic int q_size(int idx);
        case (idx)
            0: return mq0.size();
            1: return mq1.size();
            default: return mq2.size();
        endcase
    endfunction

    function automatic logic [3:0] q_front(int idx);
        if (q_size(idx) == 0) return 4'b0000;
        case (idx)
            0: return mq0[0];
            1: return mq1[0];
            default: return mq2[0];
        endcase
    endfunction

    function automatic void q_pop(int idx);
        case (idx)
            0: void'(mq0.pop_front());
            1: void'(mq1.pop_front());
            default: void'(mq2.pop_front());
        endcase
    endfunction

    function automatic void q_push(int idx, logic [3:0] e);
        case (idx)
            0: mq0.push_back(e);
            1: mq1.push_back(e);
            default: mq2.push_back(e);
        endcase
    endfunction

    function automatic void push_frame(int idx, logic [7:0] w);
        int   gap = (idx == 2) ? 0 : 2;
        logic b;
        logic last;
        for (int i = 0; i < W; i++) begin
            b    = (idx != 1) ? w[W-1-i] : w[i];
            last = (i == W - 1) && (FL == W);
            q_push(idx, {b, 1'b1, last, 1'b1});
        end
`ifdef FSM_SER_PARITY_EN
        q_push(idx, {^w, 1'b1, 1'b1, 1'b1});
`endif
        for (int g = 0; g < gap; g++) q_push(idx, 4'b0001);
    endfunction

    task automatic check(string nm, logic [8:0] act, logic [8:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %b, expected %b", nm, cyc, act, exp);
        end
    endtask

    task automatic check_all();
        logic [3:0] e;
        for (int k = 0; k < 3; k++) begin
            e = q_front(k);
            check($sformatf("u%0d outputs", k), {4'b0, bo[k], bv[k], fd[k], bz[k], rdy[k]},
                  {4'b0, e, (q_size(k) == 0)});
        end
    endtask

    task automatic cycle();
        logic acc [3];
        for (int k = 0; k < 3; k++) acc[k] = data_valid && (q_size(k) == 0);
        @(posedge clk);
        cyc++;
        for (int k = 0; k < 3; k++) begin
            if (q_size(k) > 0) q_pop(k);
            if (acc[k]) push_frame(k, data_in);
        end
        if (acc[0]) acc0.push_back(cyc);
        if (acc[2]) acc2.push_back(cyc);
        @(negedge clk);
        check_all();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(rdy[0] && rdy[1] && rdy[2]) && n < 40) begin
            cycle();
            n++;
        end
        check("idle wait timeout", {8'b0, (n >= 40)}, 9'd0);
    endtask

    task automatic send_frame(input logic [7:0] w, output logic [8:0] s0, output logic [8:0] s1,
                              output logic [8:0] f0);
        s0 = '0; s1 = '0; f0 = '0;
        data_in    = w;
        data_valid = 1'b1;
        cycle();
        data_valid = 1'b0;
        s0 = {s0[7:0], bo[0]}; s1 = {s1[7:0], bo[1]}; f0 = {f0[7:0], fd[0]};
        for (int i = 1; i < FL; i++) begin
            cycle();
            s0 = {s0[7:0], bo[0]}; s1 = {s1[7:0], bo[1]}; f0 = {f0[7:0], fd[0]};
        end
    endtask

    task automatic check_frame(string nm, logic [8:0] s0, logic [8:0] s1, logic [8:0] f0, vec_t v);
`ifdef FSM_SER_PARITY_EN
        check({nm, " msb bits"}, {1'b0, s0[8:1]}, {1'b0, v.msb});
        check({nm, " lsb bits"}, {1'b0, s1[8:1]}, {1'b0, v.lsb});
        check({nm, " parity"}, {8'b0, s0[0]}, {8'b0, v.par});
`else
        check({nm, " msb bits"}, {1'b0, s0[7:0]}, {1'b0, v.msb});
        check({nm, " lsb bits"}, {1'b0, s1[7:0]}, {1'b0, v.lsb});
`endif
        check({nm, " frame_done pos"}, f0, 9'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] s0, s1, f0;
        vec_t v0f;
        tbl[0] = '{8'hB2, 8'b10110010, 8'b01001101, 1'b0};
        tbl[1] = '{8'h07, 8'b00000111, 8'b11100000, 1'b1};
        tbl[2] = '{8'h0F, 8'b00001111, 8'b11110000, 1'b0};
        tbl[3] = '{8'hA5, 8'b10100101, 8'b10100101, 1'b0};
        tbl[4] = '{8'h80, 8'b10000000, 8'b00000001, 1'b1};
        tbl[5] = '{8'h3C, 8'b00111100, 8'b00111100, 1'b0};

        reset      = 1'b1;
        data_valid = 1'b0;
        data_in    = 8'h00;
        #12;
        for (int k = 0; k < 3; k++)
            check($sformatf("u%0d reset outputs", k), {5'b0, bo[k], bv[k], fd[k], bz[k]}, 9'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) check($sformatf("u%0d ready after reset", k), {8'b0, rdy[k]}, 9'd1);

        // Table-driven frames, with explicit gap/ready timing on the first one.
        for (int t = 0; t < 6; t++) begin
            wait_idle();
            send_frame(tbl[t].w, s0, s1, f0);
            check_frame($sformatf("vec%0d", t), s0, s1, f0, tbl[t]);
            if (t == 0) begin
                cycle();
                check("gap1 busy/bit", {7'b0, bz[0], bo[0]}, 9'b10);
                check("nogap ready", {7'b0, rdy[2], bz[2]}, 9'b10);
                cycle();
                check("gap2 busy/bit", {7'b0, bz[0], bo[0]}, 9'b10);
                cycle();
                check("ready after gap", {8'b0, rdy[0]}, 9'd1);
            end
        end

        // Back-to-back with data_valid held high.
        wait_idle();
        acc0.delete();
        acc2.delete();
        data_in    = 8'hFF;
        data_valid = 1'b1;
        cycle();
        data_in = 8'h00;
        for (int i = 0; i < 24; i++) cycle();
        data_valid = 1'b0;
        if (acc0.size() >= 2) check("b2b spacing gap2", 9'(acc0[1] - acc0[0]), 9'(FL + 2 + 1));
        else check("b2b accepts gap2", 9'(acc0.size()), 9'd2);
        if (acc2.size() >= 2) check("b2b spacing gap0", 9'(acc2[1] - acc2[0]), 9'(FL + 1));
        else check("b2b accepts gap0", 9'(acc2.size()), 9'd2);

        // Reset after three bits of a frame, then a clean frame.
        wait_idle();
        data_in    = 8'hB2;
        data_valid = 1'b1;
        cycle();
        data_valid = 1'b0;
        cycle();
        cycle();
        #2 reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++)
            check($sformatf("u%0d mid-frame reset", k), {5'b0, bo[k], bv[k], fd[k], bz[k]}, 9'd0);
        mq0.delete(); mq1.delete(); mq2.delete();
        @(negedge clk);
        check("no frame_done in reset", {6'b0, fd[0], fd[1], fd[2]}, 9'd0);
        reset = 1'b0;
        #1;
        check("ready after mid reset", {6'b0, rdy[0], rdy[1], rdy[2]}, 9'b111);
        v0f = tbl[2];
        send_frame(8'h0F, s0, s1, f0);
        check_frame("post-reset 0F", s0, s1, f0, v0f);

        // Randomized traffic against the model.
        wait_idle();
        for (int i = 0; i < 400; i++) begin
            data_valid = ($urandom_range(0, 3) != 0);
            data_in    = 8'($urandom);
            cycle();
        end
        data_valid = 1'b0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
